loader_rom: RTL and testbench
=============================

# loader_rom

Parametrised, loader-writable boot ROM for the TS-Conf core. The loader programs it byte by byte over the shared loader bus, and the CPU side reads it as a synchronous ROM. The data width is configurable with per-byte-lane writes, and the read latency is selectable. Bank decoding lets several instances share one loader bus. The block also runs a load-session state machine that reports busy, a completion pulse, a byte count and a checksum to the loader firmware.

## Interface
Parameters:
- ADDR_W, 14, word address width; depth = 2^ADDR_W words.
- DATA_W, 8, read data width; legal values are 8, 16 and 32. LB = log2(DATA_W/8).
- BANK, 8'h00, value that loader_a[31:24] must equal for this instance.
- READ_LAT, 1, read latency in cycles; legal values are 1 and 2.

Ports:
- clk  in  1  system clock, sole clock domain.
- reset  in  1  synchronous, active-high reset.
- a  in  ADDR_W  CPU word address.
- rd  in  1  read strobe.
- dout  out  DATA_W  read data; lane k is bits [8k+7:8k], little-endian.
- dout_valid  out  1  high for one cycle when dout carries a read result.
- loader_act  in  1  load session active.
- loader_a  in  32  loader byte address.
- loader_d  in  8  loader data byte.
- loader_wr  in  1  byte write strobe.
- lock  in  1  write protect; while high, all loader writes are ignored.
- busy  out  1  high while state is LOAD or FINISH.
- load_done  out  1  one-cycle pulse at the end of a session.
- byte_count  out  ADDR_W+LB+1  bytes accepted in the current or last session.
- checksum  out  16  modulo-2^16 sum of the bytes accepted.

## Operation
- Byte decode:
  - lane = loader_a[LB-1:0] (LB=0 means a single lane).
  - word = loader_a[LB+ADDR_W-1:LB].
- A byte is accepted when all of the following hold:
  - state = LOAD
  - loader_wr = 1
  - lock = 0
  - loader_a[31:24] = BANK
  - loader_a[23:LB+ADDR_W] is all zero
- Any other loader write is silently dropped. It causes no memory change and no count or checksum update.
- An accepted byte writes only lane `lane` of word `word`. The other lanes of that word are preserved, so storage is one 8-bit array per lane.
- Per accepted byte:
  - byte_count increments by 1 and saturates at all-ones.
  - checksum becomes checksum + loader_d, truncated to 16 bits.
- States:
  - IDLE → LOAD when loader_act = 1. On entry, byte_count and checksum clear to 0; the byte accepted in that same cycle is counted on top of zero.
  - LOAD → FINISH when loader_act = 0.
  - FINISH → IDLE unconditionally after one cycle; load_done = 1 during FINISH.
  - If loader_act rises again while in FINISH, the next cycle still goes to IDLE, and LOAD is entered one cycle later.
- Memory contents are never cleared. Neither reset nor a new session erases them.
- Reads:
  - rd is sampled with a only in IDLE.
  - A read sampled while busy is discarded: dout_valid stays 0 and dout holds its previous value.
- A read in IDLE never collides with a write, because writes occur only in LOAD.

## Timing
- Reset values: dout = 0, dout_valid = 0, busy = 0, load_done = 0, byte_count = 0, checksum = 0, state = IDLE. The read pipeline is flushed.
- Read latency:
  - rd/a sampled at edge N produce dout and dout_valid = 1 after edge N+READ_LAT.
  - Back-to-back reads give one result per cycle.
  - When dout_valid = 0, dout holds its last value.
- Read pipeline across a state change: a read accepted in IDLE that is still in flight when LOAD is entered still completes with pre-write data.
- Write timing: an accepted byte updates memory, byte_count and checksum at the same edge.
- busy rises at the edge after loader_act is first seen high. It falls at the edge that leaves FINISH, which is 2 cycles after loader_act drops.
- Reset asserted mid-session:
  - The session aborts immediately and load_done is not pulsed.
  - byte_count and checksum return to 0.
  - Bytes already written stay in memory.
- Reset has priority over every other input in the same cycle.

## Test plan
- DATA_W=8, BANK=0:
  - Stimulus: session writes 0x12, 0x34, 0x56 to bytes 0..2, then loader_act drops.
  - Required: load_done pulses once, byte_count = 3, checksum = 0x009C.
  - Required: rd a=1 gives dout = 0x34 with dout_valid exactly READ_LAT cycles later.
- DATA_W=32:
  - Stimulus: write bytes 0xAA to byte address 5 and 0xBB to byte address 7.
  - Required: a read of word 1 returns 0xBB00AA00 when that word was previously zero; lanes 0 and 2 are untouched.
- Dropped writes:
  - Stimulus: writes with loader_a[31:24] = 0x01 while BANK = 0; a write with lock = 1; a write with loader_act = 0.
  - Required: memory unchanged, byte_count = 0, checksum = 0, and no load_done without a session.
- Reads while busy:
  - Stimulus: rd pulses during LOAD.
  - Required: dout_valid stays 0 and dout is unchanged.
  - Stimulus: rd in the last IDLE cycle before LOAD.
  - Required: that read returns pre-load data.
- Reset mid-session:
  - Stimulus: reset after 2 accepted bytes.
  - Required: busy = 0, byte_count = 0, checksum = 0, no load_done; the 2 bytes read back correctly afterwards.
- Checksum and count limits:
  - Stimulus: 300 writes of 0xFF.
  - Required: checksum = (300×255) mod 65536 = 0x2AD4.
  - Stimulus: ADDR_W=2, DATA_W=8, 10 writes.
  - Required: byte_count saturates at 7.

Source files
------------

// File: rtl/loader_rom.sv
// loader_rom: loader-writable boot ROM for the TS-Conf core.
// The loader fills it byte by byte during a load session; the CPU reads it
// as a synchronous ROM with 1 or 2 cycles of latency. A small session FSM
// reports busy, a completion pulse, a byte count and a 16-bit checksum.
module loader_rom #(
    parameter int          ADDR_W   = 14,
    parameter int          DATA_W   = 8,
    parameter logic [7:0]  BANK     = 8'h00,
    parameter int          READ_LAT = 1,
    localparam int         LB       = $clog2(DATA_W / 8)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   a,
    input  logic                rd,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid,
    input  logic                loader_act,
    input  logic [31:0]         loader_a,
    input  logic [7:0]          loader_d,
    input  logic                loader_wr,
    input  logic                lock,
    output logic                busy,
    output logic                load_done,
    output logic [ADDR_W+LB:0]  byte_count,
    output logic [15:0]         checksum
);

    localparam int NL    = DATA_W / 8;
    localparam int LBW   = (LB > 0) ? LB : 1;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = ADDR_W + LB + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Byte count advances by one and sticks at all-ones.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
        if (&cnt)
            return cnt;
        return cnt + 1'b1;
    endfunction

    // Checksum is a plain modulo-2^16 sum of accepted bytes.
    function automatic logic [15:0] csum_add(input logic [15:0] sum, input logic [7:0] d);
        return sum + {8'h00, d};
    endfunction

    // Loader address decode: byte lane, word index, bank and range qualifiers.
    logic [LBW-1:0]    lane;
    logic [ADDR_W-1:0] word;
    logic              in_bank;
    logic              in_range;
    logic              accept;

    assign lane     = (LB == 0) ? '0 : loader_a[LBW-1:0];
    assign word     = ADDR_W'(loader_a >> LB);
    assign in_bank  = (loader_a[31:24] == BANK);
    assign in_range = ((loader_a[23:0] >> (LB + ADDR_W)) == 24'd0);
    // Reset wins over a write strobe arriving in the same cycle.
    assign accept   = !reset && (state == S_LOAD) && loader_wr && !lock && in_bank && in_range;

    // Session state register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Session next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        load_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (loader_act)
                    state_nxt = S_LOAD;
            end
            S_LOAD: begin
                busy = 1'b1;
                if (!loader_act)
                    state_nxt = S_FINISH;
            end
            S_FINISH: begin
                busy      = 1'b1;
                load_done = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Count and checksum clear on session entry and track accepted bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_count <= '0;
            checksum   <= '0;
        end else if (state == S_IDLE && loader_act) begin
            byte_count <= '0;
            checksum   <= '0;
        end else if (accept) begin
            byte_count <= sat_inc(byte_count);
            checksum   <= csum_add(checksum, loader_d);
        end
    end

    // Stage p0: CPU read request, taken only while no session is running.
    logic              vld_p0;
    logic [ADDR_W-1:0] addr_p0;

    // Read request valid; discarded while busy.
    always_ff @(posedge clk) begin
        if (reset)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= rd && (state == S_IDLE);
    end

    // Read address capture.
    always_ff @(posedge clk) begin
        if (rd)
            addr_p0 <= a;
    end

    // Stage p1: per-lane memory read.
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;

    // Read valid follows the memory access.
    always_ff @(posedge clk) begin
        if (reset)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= vld_p0;
    end

    for (genvar k = 0; k < NL; k++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rdata_p1;

        // Lane write; contents survive reset and new sessions.
        always_ff @(posedge clk) begin
            if (accept && lane == LBW'(k))
                mem[word] <= loader_d;
        end

        // Lane read; holds its value when no read is in flight.
        always_ff @(posedge clk) begin
            if (reset)
                rdata_p1 <= '0;
            else if (vld_p0)
                rdata_p1 <= mem[addr_p0];
        end

        assign data_p1[8*k +: 8] = rdata_p1;
    end

    // Stage p2: optional output register for two-cycle latency.
    if (READ_LAT == 2) begin : g_lat2
        logic              vld_p2;
        logic [DATA_W-1:0] data_p2;

        // Extra output stage; data held when no result arrives.
        always_ff @(posedge clk) begin
            if (reset) begin
                vld_p2  <= 1'b0;
                data_p2 <= '0;
            end else begin
                vld_p2 <= vld_p1;
                if (vld_p1)
                    data_p2 <= data_p1;
            end
        end

        assign dout       = data_p2;
        assign dout_valid = vld_p2;
    end else begin : g_lat1
        assign dout       = data_p1;
        assign dout_valid = vld_p1;
    end

endmodule

// File: tb/tb_loader_rom.sv
// Testbench for loader_rom: three instances share one loader bus with
// different banks (8-bit/lat1, 32-bit/lat2, tiny 8-bit for saturation).
module tb_loader_rom;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        loader_act;
    logic [31:0] loader_a;
    logic [7:0]  loader_d;
    logic        loader_wr;
    logic        lock;

    // 8-bit instance, bank 0x00, latency 1
    logic [13:0] a8;
    logic        rd8;
    logic [7:0]  dout8;
    logic        v8, busy8, done8;
    logic [14:0] bc8;
    logic [15:0] cs8;

    // 32-bit instance, bank 0x10, latency 2
    logic [9:0]  a32;
    logic        rd32;
    logic [31:0] dout32;
    logic        v32, busy32, done32;
    logic [12:0] bc32;
    logic [15:0] cs32;

    // tiny instance, bank 0x20, ADDR_W=2
    logic [1:0]  asm;
    logic        rdsm;
    logic [7:0]  doutsm;
    logic        vsm, busysm, donesm;
    logic [2:0]  bcsm;
    logic [15:0] cssm;

    loader_rom #(.ADDR_W(14), .DATA_W(8), .BANK(8'h00), .READ_LAT(1)) u8 (
        .clk(clk), .reset(reset), .a(a8), .rd(rd8), .dout(dout8), .dout_valid(v8),
        .loader_act(loader_act), .loader_a(loader_a), .loader_d(loader_d),
        .loader_wr(loader_wr), .lock(lock), .busy(busy8), .load_done(done8),
        .byte_count(bc8), .checksum(cs8));

    loader_rom #(.ADDR_W(10), .DATA_W(32), .BANK(8'h10), .READ_LAT(2)) u32 (
        .clk(clk), .reset(reset), .a(a32), .rd(rd32), .dout(dout32), .dout_valid(v32),
        .loader_act(loader_act), .loader_a(loader_a), .loader_d(loader_d),
        .loader_wr(loader_wr), .lock(lock), .busy(busy32), .load_done(done32),
        .byte_count(bc32), .checksum(cs32));

    loader_rom #(.ADDR_W(2), .DATA_W(8), .BANK(8'h20), .READ_LAT(1)) usm (
        .clk(clk), .reset(reset), .a(asm), .rd(rdsm), .dout(doutsm), .dout_valid(vsm),
        .loader_act(loader_act), .loader_a(loader_a), .loader_d(loader_d),
        .loader_wr(loader_wr), .lock(lock), .busy(busysm), .load_done(donesm),
        .byte_count(bcsm), .checksum(cssm));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q32[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int v8_cnt = 0;
    int done8_cnt = 0;
    int done32_cnt = 0;
    int donesm_cnt = 0;

    // Scoreboard: pop expected read results as the DUTs deliver them
    always @(negedge clk) begin
        exp_t e;
        if (done8)  done8_cnt++;
        if (done32) done32_cnt++;
        if (donesm) donesm_cnt++;
        if (v8) begin
            v8_cnt++;
            if (q8.size() == 0) begin
                check("u8_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                check("u8_rdata", {24'd0, dout8}, e.data);
                check("u8_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (v32) begin
            if (q32.size() == 0) begin
                check("u32_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q32.pop_front();
                check("u32_rdata", dout32, e.data);
                check("u32_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (vsm) check("usm_unexpected_valid", 32'd1, 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lw(input logic [31:0] addr, input logic [7:0] d);
        loader_a  = addr;
        loader_d  = d;
        loader_wr = 1'b1;
        tick();
        loader_wr = 1'b0;
    endtask

    task automatic read8(input logic [13:0] addr, input logic [7:0] exp_d);
        a8  = addr;
        rd8 = 1'b1;
        q8.push_back('{data: {24'd0, exp_d}, cyc: cyc + 2});
        tick();
        rd8 = 1'b0;
    endtask

    task automatic read32(input logic [9:0] addr, input logic [31:0] exp_d);
        a32  = addr;
        rd32 = 1'b1;
        q32.push_back('{data: exp_d, cyc: cyc + 3});
        tick();
        rd32 = 1'b0;
    endtask

    task automatic start_session();
        loader_act = 1'b1;
        check("busy_before_entry", {31'd0, busy8}, 32'd0);
        tick();
        check("busy_after_entry", {31'd0, busy8}, 32'd1);
    endtask

    task automatic end_session();
        loader_act = 1'b0;
        tick();
        check("done_in_finish", {31'd0, done8}, 32'd1);
        check("busy_in_finish", {31'd0, busy8}, 32'd1);
        tick();
        check("busy_after_finish", {31'd0, busy8}, 32'd0);
        check("done_after_finish", {31'd0, done8}, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && (q8.size() != 0 || q32.size() != 0); i++)
            tick();
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q32_drained", 32'(q32.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] dout_save;
        int         vcnt_save;

        reset = 1'b1; loader_act = 1'b0; loader_a = '0; loader_d = '0;
        loader_wr = 1'b0; lock = 1'b0;
        a8 = '0; rd8 = 1'b0; a32 = '0; rd32 = 1'b0; asm = '0; rdsm = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_dout8", {24'd0, dout8}, 32'd0);
        check("rst_valid8", {31'd0, v8}, 32'd0);
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_done8", {31'd0, done8}, 32'd0);
        check("rst_bc8", {17'd0, bc8}, 32'd0);
        check("rst_cs8", {16'd0, cs8}, 32'd0);
        check("rst_dout32", dout32, 32'd0);
        check("rst_doutsm", {24'd0, doutsm}, 32'd0);
        reset = 1'b0;
        tick();

        // Session 1: bytes 0..2 of u8, zero word 1 of u32, reads while busy
        start_session();
        lw(32'h0000_0000, 8'h12);
        lw(32'h0000_0001, 8'h34);
        dout_save = dout8;
        vcnt_save = v8_cnt;
        a8 = 14'd1; rd8 = 1'b1;
        lw(32'h0000_0002, 8'h56);
        lw(32'h1000_0004, 8'h00);
        rd8 = 1'b0;
        lw(32'h1000_0005, 8'h00);
        lw(32'h1000_0006, 8'h00);
        lw(32'h1000_0007, 8'h00);
        check("busy_read_no_valid", 32'(v8_cnt), 32'(vcnt_save));
        check("busy_read_dout_held", {24'd0, dout8}, {24'd0, dout_save});
        check("s1_bc8_mid", {17'd0, bc8}, 32'd3);
        end_session();
        check("s1_done_count", 32'(done8_cnt), 32'd1);
        check("s1_bc8", {17'd0, bc8}, 32'd3);
        check("s1_cs8", {16'd0, cs8}, 32'h009C);
        check("s1_bc32", {19'd0, bc32}, 32'd4);
        check("s1_cs32", {16'd0, cs32}, 32'd0);

        // Reads of u8, single then back-to-back
        read8(14'd1, 8'h34);
        tick(); tick();
        read8(14'd0, 8'h12);
        read8(14'd1, 8'h34);
        read8(14'd2, 8'h56);
        drain();

        // Session 2: lane writes on u32 and dropped writes for u8
        start_session();
        lw(32'h1000_0005, 8'hAA);
        lw(32'h1000_0007, 8'hBB);
        lw(32'h0100_0000, 8'h77);
        lock = 1'b1;
        lw(32'h0000_0000, 8'h99);
        lock = 1'b0;
        lw(32'h0000_4000, 8'h66);
        check("s2_bc8_clear", {17'd0, bc8}, 32'd0);
        end_session();
        check("s2_bc8", {17'd0, bc8}, 32'd0);
        check("s2_cs8", {16'd0, cs8}, 32'd0);
        check("s2_bc32", {19'd0, bc32}, 32'd2);
        check("s2_cs32", {16'd0, cs32}, 32'h0165);
        check("s2_done_count", 32'(done8_cnt), 32'd2);
        // Write with no session active
        lw(32'h0000_0000, 8'h88);
        tick(); tick();
        check("idle_write_no_done", 32'(done8_cnt), 32'd2);
        check("idle_write_bc8", {17'd0, bc8}, 32'd0);
        read8(14'd0, 8'h12);
        read32(10'd1, 32'hBB00_AA00);
        drain();

        // Session 3: read in last IDLE cycle, then reset after 2 bytes
        a8 = 14'd2; rd8 = 1'b1; loader_act = 1'b1;
        q8.push_back('{data: 32'h56, cyc: cyc + 2});
        tick();
        rd8 = 1'b0;
        lw(32'h0000_0002, 8'hEE);
        lw(32'h0000_0003, 8'hC3);
        check("s3_bc8_mid", {17'd0, bc8}, 32'd2);
        reset = 1'b1; loader_act = 1'b0;
        tick();
        check("mid_rst_busy", {31'd0, busy8}, 32'd0);
        check("mid_rst_bc8", {17'd0, bc8}, 32'd0);
        check("mid_rst_cs8", {16'd0, cs8}, 32'd0);
        reset = 1'b0;
        tick(); tick(); tick();
        check("mid_rst_no_done", 32'(done8_cnt), 32'd2);
        read8(14'd2, 8'hEE);
        read8(14'd3, 8'hC3);
        drain();

        // Session 4: checksum wrap on u8 and count saturation on usm
        start_session();
        check("s4_bcsm_start", {29'd0, bcsm}, 32'd0);
        for (int i = 0; i < 300; i++)
            lw(32'h0000_0100 + 32'(i), 8'hFF);
        for (int i = 0; i < 10; i++)
            lw(32'h2000_0000 | 32'(i % 4), 8'(i + 1));
        end_session();
        check("s4_cs8_wrap", {16'd0, cs8}, 32'h2AD4);
        check("s4_bc8", {17'd0, bc8}, 32'd300);
        check("s4_bcsm_sat", {29'd0, bcsm}, 32'd7);
        check("s4_cssm", {16'd0, cssm}, 32'h0037);
        check("s4_donesm_count", 32'(donesm_cnt), 32'd3);
        read8(14'h100, 8'hFF);
        read8(14'd0, 8'h12);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
